match_lock_fsm: RTL and testbench
=================================

# match_lock_fsm

Sequential consumer of the 4-bit equality comparator's `eq` output. It samples the comparison result on a strobe and counts consecutive matches. After a set number of consecutive matches it asserts a timed unlock window; after repeated mismatches it enters a timed lockout. It sits directly downstream of the comparator and drives the lock/alarm indicators of the design.

## Interface
- MATCHES_NEEDED, 3, consecutive matching samples required to unlock; legal range 1..7
- MAX_FAILS, 3, mismatching samples (since last unlock/clear) that trigger lockout; legal range 1..3
- UNLOCK_CYCLES, 8, cycles `unlocked` stays high; legal range 1..255
- LOCKOUT_CYCLES, 16, cycles `alarm` stays high; legal range 1..255
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- sample  input  1  strobe: `eq` is valid this cycle and is consumed if `ready`=1
- eq  input  1  comparator result (1 = A equals B)
- clear  input  1  synchronous abort: return to COLLECT, counters zeroed (ignored in LOCKOUT)
- ready  output  1  high only in COLLECT; samples accepted only when high
- unlocked  output  1  high in OPEN
- alarm  output  1  high in LOCKOUT
- match_cnt  output  3  current consecutive-match count
- fail_cnt  output  2  current mismatch count

## Operation
- States: COLLECT, OPEN, LOCKOUT. Internal 8-bit down-counter `timer`.
- Reset (rst_n=0, async): state=COLLECT, match_cnt=0, fail_cnt=0, timer=0; outputs ready=1, unlocked=0, alarm=0.
- COLLECT, priority clear > sample:
  - clear=1: match_cnt=0, fail_cnt=0, stay COLLECT; simultaneous sample discarded.
  - sample&eq: match_cnt+1; if new value == MATCHES_NEEDED -> OPEN, match_cnt=0, fail_cnt=0, timer=UNLOCK_CYCLES.
  - sample&!eq: match_cnt=0, fail_cnt+1; if new value == MAX_FAILS -> LOCKOUT, fail_cnt=0, timer=LOCKOUT_CYCLES.
  - No sample: hold all counters (no timeout between samples).
- OPEN: sample ignored (not counted, no error). clear=1 -> COLLECT next cycle (early relock), timer=0. Otherwise timer decrements; when timer==1 at an edge -> COLLECT.
- LOCKOUT: sample and clear both ignored. timer decrements; when timer==1 at an edge -> COLLECT, counters already zero.
- Counters never wrap: parameter limits guarantee transitions before overflow.
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.

## Timing
- Sample consumed at the rising edge where sample=1 and ready=1; effect on match_cnt/fail_cnt/state visible the following cycle.
- Unlock latency: the MATCHES_NEEDED-th matching sample at edge N -> unlocked=1 from edge N through edge N+UNLOCK_CYCLES, i.e. high exactly UNLOCK_CYCLES cycles; ready=1 again at edge N+UNLOCK_CYCLES.
- Lockout: alarm high exactly LOCKOUT_CYCLES cycles, same counting rule.
- ready falls in the same cycle unlocked/alarm rises; back-to-back sample on the entry cycle is dropped.
- A mismatch resets match_cnt but not fail_cnt; a match does not reset fail_cnt.
- rst_n asserted mid-OPEN or mid-LOCKOUT: outputs return to reset values immediately (asynchronously), timer cleared.
- clear asserted in the same cycle as the unlocking sample: clear wins, state COLLECT, counters 0.

## Test plan
- Reset, then sample eq=1 on 3 consecutive cycles -> match_cnt 1,2 then unlocked=1 for exactly 8 cycles, ready=0 during, ready=1 and match_cnt=0 after.
- Samples eq=1,1,0,1,1,1 -> match_cnt 1,2,0,1,2, fail_cnt=1 after the mismatch, unlock after the last sample, fail_cnt=0 once unlocked.
- Three sample eq=0 -> fail_cnt 1,2, then alarm=1 for exactly 16 cycles; samples and clear pulses during lockout change nothing; returns to COLLECT with counters 0.
- Two matches then clear=1 together with a third matching sample -> no unlock, match_cnt=0, fail_cnt=0.
- In OPEN, assert clear at cycle 3 -> unlocked drops next cycle, ready=1; samples during OPEN before the clear are not counted.
- Drop rst_n mid-LOCKOUT (cycle 5) -> alarm=0 and ready=1 without waiting for a clock edge; after release, 3 matches unlock normally.

Source files
------------

// File: rtl/match_lock_fsm.sv
// Match/lockout controller fed by the equality comparator's eq output.
// Counts consecutive matching samples to open a timed unlock window; repeated mismatches trigger a timed lockout.
module match_lock_fsm #(
  parameter int MATCHES_NEEDED = 3,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       eq,
  input  logic       clear,
  output logic       ready,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] match_cnt,
  output logic [1:0] fail_cnt
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] OPEN    = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

  localparam logic [2:0] MATCH_LIMIT  = 3'(MATCHES_NEEDED);
  localparam logic [1:0] FAIL_LIMIT   = 2'(MAX_FAILS);
  localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES);
  localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES);

  logic [1:0] state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [2:0] match_nxt, match_inc;
  logic [1:0] fail_nxt, fail_inc;

  assign match_inc = match_cnt + 3'd1;
  assign fail_inc  = fail_cnt + 2'd1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    match_nxt = match_cnt;
    fail_nxt  = fail_cnt;
    case (state)
      COLLECT: begin
        if (clear) begin
          match_nxt = 3'd0;
          fail_nxt  = 2'd0;
        end else if (sample) begin
          if (eq) begin
            if (match_inc == MATCH_LIMIT) begin
              state_nxt = OPEN;
              match_nxt = 3'd0;
              fail_nxt  = 2'd0;
              timer_nxt = UNLOCK_LOAD;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            match_nxt = 3'd0;
            if (fail_inc == FAIL_LIMIT) begin
              state_nxt = LOCKOUT;
              fail_nxt  = 2'd0;
              timer_nxt = LOCKOUT_LOAD;
            end else begin
              fail_nxt = fail_inc;
            end
          end
        end
      end
      OPEN: begin
        // A zero timer is treated as expired so the window can never stick open.
        if (clear || timer <= 8'd1) begin
          state_nxt = COLLECT;
          timer_nxt = 8'd0;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      LOCKOUT: begin
        if (timer <= 8'd1) begin
          state_nxt = COLLECT;
          timer_nxt = 8'd0;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: begin
        state_nxt = COLLECT;
        timer_nxt = 8'd0;
        match_nxt = 3'd0;
        fail_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      timer     <= 8'd0;
      match_cnt <= 3'd0;
      fail_cnt  <= 2'd0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      match_cnt <= match_nxt;
      fail_cnt  <= fail_nxt;
    end
  end

  assign ready    = (state == COLLECT);
  assign unlocked = (state == OPEN);
  assign alarm    = (state == LOCKOUT);

endmodule

// File: tb/tb_match_lock_fsm.sv
// Directed bench for match_lock_fsm: vector table plus hand-written reset/lockout sequences.
module tb_match_lock_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample = 1'b0;
  logic       eq = 1'b0;
  logic       clear = 1'b0;
  logic       ready, unlocked, alarm;
  logic [2:0] match_cnt;
  logic [1:0] fail_cnt;

  int passed = 0;
  int total  = 0;

  match_lock_fsm #(
    .MATCHES_NEEDED(3),
    .MAX_FAILS(3),
    .UNLOCK_CYCLES(8),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample(sample),
    .eq(eq),
    .clear(clear),
    .ready(ready),
    .unlocked(unlocked),
    .alarm(alarm),
    .match_cnt(match_cnt),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // n: number of cycles the inputs are held; exp is checked after every one of them.
  typedef struct {
    int         n;
    logic       s;
    logic       e;
    logic       c;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] pk(logic r, logic u, logic a, logic [2:0] m, logic [1:0] f);
    return {r, u, a, m, f};
  endfunction

  task automatic add(int n, logic s, logic e, logic c, logic [7:0] exp);
    vec_t v;
    v.n = n; v.s = s; v.e = e; v.c = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, logic [7:0] exp);
    logic [7:0] act;
    act = {ready, unlocked, alarm, match_cnt, fail_cnt};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got rdy/unl/alm/mc/fc=%b required %b", nm, act, exp);
  endtask

  task automatic cyc(logic s, logic e, logic c);
    @(negedge clk);
    sample = s; eq = e; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // basic unlock, samples in OPEN ignored, 8-cycle window
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd0));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd2, 2'd0));
    add(1, 1, 1, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(7, 1, 1, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(1, 0, 0, 0, pk(1, 0, 0, 3'd0, 2'd0));
    // 1,1,0,1,1,1: mismatch resets match only
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd0));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd2, 2'd0));
    add(1, 1, 0, 0, pk(1, 0, 0, 3'd0, 2'd1));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd1));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd2, 2'd1));
    add(1, 1, 1, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(7, 0, 0, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(1, 0, 0, 0, pk(1, 0, 0, 3'd0, 2'd0));
    // lockout: samples and clear ignored for 16 cycles
    add(1, 1, 0, 0, pk(1, 0, 0, 3'd0, 2'd1));
    add(1, 1, 0, 0, pk(1, 0, 0, 3'd0, 2'd2));
    add(1, 1, 0, 0, pk(0, 0, 1, 3'd0, 2'd0));
    add(15, 1, 1, 1, pk(0, 0, 1, 3'd0, 2'd0));
    add(1, 0, 0, 0, pk(1, 0, 0, 3'd0, 2'd0));
    // clear beats the unlocking sample and zeroes fail_cnt
    add(1, 1, 0, 0, pk(1, 0, 0, 3'd0, 2'd1));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd1));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd2, 2'd1));
    add(1, 1, 1, 1, pk(1, 0, 0, 3'd0, 2'd0));
    add(1, 0, 0, 0, pk(1, 0, 0, 3'd0, 2'd0));
    // early relock by clear in OPEN; earlier OPEN samples not counted
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd0));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd2, 2'd0));
    add(1, 1, 1, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(2, 1, 1, 0, pk(0, 1, 0, 3'd0, 2'd0));
    add(1, 0, 0, 1, pk(1, 0, 0, 3'd0, 2'd0));
    add(1, 1, 1, 0, pk(1, 0, 0, 3'd1, 2'd0));
    add(1, 0, 0, 1, pk(1, 0, 0, 3'd0, 2'd0));

    #2;
    check("reset_state", pk(1, 0, 0, 3'd0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(vecs[i].s, vecs[i].e, vecs[i].c);
        check($sformatf("vec%0d_cyc%0d", i, k), vecs[i].exp);
      end
    end

    // async reset in the middle of lockout
    cyc(1, 0, 0); check("lk_fail1", pk(1, 0, 0, 3'd0, 2'd1));
    cyc(1, 0, 0); check("lk_fail2", pk(1, 0, 0, 3'd0, 2'd2));
    cyc(1, 0, 0); check("lk_enter", pk(0, 0, 1, 3'd0, 2'd0));
    for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    check("lk_mid", pk(0, 0, 1, 3'd0, 2'd0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lockout", pk(1, 0, 0, 3'd0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1, 1, 0); check("post_rst_m1", pk(1, 0, 0, 3'd1, 2'd0));
    cyc(1, 1, 0); check("post_rst_m2", pk(1, 0, 0, 3'd2, 2'd0));
    cyc(1, 1, 0); check("post_rst_open", pk(0, 1, 0, 3'd0, 2'd0));
    for (int k = 0; k < 3; k++) cyc(0, 0, 0);
    check("post_rst_open_mid", pk(0, 1, 0, 3'd0, 2'd0));

    // async reset in the middle of OPEN
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_open", pk(1, 0, 0, 3'd0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0); check("final_m1", pk(1, 0, 0, 3'd1, 2'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
